// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute control FSM for the phase-1 datapath.
// Steps T0..T6 per instruction, waits on mem_ready during fetch, drives the
// one-hot bus-source select, register enables, ALU op and memory read.
module control_sequencer #(
  parameter int OP_W  = 5,
  parameter int REG_W = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  mem_ready,
  input  logic [31:0]           ir,
  output logic [31:0]           select,
  output logic [(1<<REG_W)-1:0] reg_in,
  output logic                  y_enable,
  output logic                  hi_enable,
  output logic                  lo_enable,
  output logic                  z_enable,
  output logic                  pc_enable,
  output logic                  mar_enable,
  output logic                  mdr_enable,
  output logic                  ir_enable,
  output logic                  read,
  output logic                  inc_pc,
  output logic [OP_W-1:0]       alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);

  localparam int NREG    = 1 << REG_W;
  localparam int SEL_ZHI = 18;
  localparam int SEL_ZLO = 19;
  localparam int SEL_PC  = 20;
  localparam int SEL_MDR = 21;
  localparam int SEL_C   = 23;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   ill_q;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] ra, rb, rc;
  logic             is_alu, is_imm, is_md, is_un;
  // Low IR bits carry the immediate, which the datapath sign-extends itself.
  logic             unused_ir_low;

  assign op            = ir[31 -: OP_W];
  assign ra            = ir[26 -: REG_W];
  assign rb            = ir[22 -: REG_W];
  assign rc            = ir[18 -: REG_W];
  assign unused_ir_low = ^ir[14:0];

  assign is_alu = (op >= OP_W'(3))  && (op <= OP_W'(11));
  assign is_imm = (op >= OP_W'(12)) && (op <= OP_W'(14));
  assign is_md  = (op == OP_W'(15)) || (op == OP_W'(16));
  assign is_un  = (op == OP_W'(17)) || (op == OP_W'(18));

  function automatic logic [31:0] src_bit(input int idx);
    return 32'd1 << idx;
  endfunction

  function automatic logic [NREG-1:0] dst_bit(input logic [REG_W-1:0] r);
    return {{(NREG-1){1'b0}}, 1'b1} << r;
  endfunction

  // State register and illegal-opcode flag captured in T3 for the DONE pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_T3)
        ill_q <= !(is_alu || is_imm || is_md || is_un);
      else if (state == S_T0)
        ill_q <= 1'b0;
    end
  end

  // Next-state sequencing; opcode class decides the length of the execute phase.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1,
      S_T1W:   state_nxt = mem_ready ? S_T2 : S_T1W;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = (is_alu || is_imm || is_md || is_un) ? S_T4 : S_DONE;
      S_T4:    state_nxt = (is_alu || is_imm || is_md) ? S_T5 : S_DONE;
      S_T5:    state_nxt = is_md ? S_T6 : S_DONE;
      S_T6:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control word for the current step; at most one bus source per step.
  always_comb begin
    select     = '0;
    reg_in     = '0;
    y_enable   = 1'b0;
    hi_enable  = 1'b0;
    lo_enable  = 1'b0;
    z_enable   = 1'b0;
    pc_enable  = 1'b0;
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
    ir_enable  = 1'b0;
    read       = 1'b0;
    inc_pc     = 1'b0;
    alu_op     = '0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    illegal    = (state == S_DONE) && ill_q;
    case (state)
      S_T0: begin
        select     = src_bit(SEL_PC);
        mar_enable = 1'b1;
        inc_pc     = 1'b1;
        z_enable   = 1'b1;
      end
      S_T1: begin
        select     = src_bit(SEL_ZLO);
        pc_enable  = 1'b1;
        read       = 1'b1;
        mdr_enable = 1'b1;
      end
      S_T1W: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
      end
      S_T2: begin
        select    = src_bit(SEL_MDR);
        ir_enable = 1'b1;
      end
      S_T3: begin
        if (is_alu || is_imm) begin
          select   = src_bit(int'(rb));
          y_enable = 1'b1;
        end else if (is_md) begin
          select   = src_bit(int'(ra));
          y_enable = 1'b1;
        end else if (is_un) begin
          select   = src_bit(int'(rb));
          alu_op   = op;
          z_enable = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu || is_imm || is_md) begin
          select   = is_alu ? src_bit(int'(rc)) :
                     is_imm ? src_bit(SEL_C) : src_bit(int'(rb));
          alu_op   = op;
          z_enable = 1'b1;
        end else if (is_un) begin
          select = src_bit(SEL_ZLO);
          reg_in = dst_bit(ra);
        end
      end
      S_T5: begin
        select = src_bit(SEL_ZLO);
        if (is_md) lo_enable = 1'b1;
        else       reg_in    = dst_bit(ra);
      end
      S_T6: begin
        select    = src_bit(SEL_ZHI);
        hi_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
